// File: rtl/adbg_or1k_mc_pkg.sv
// Shared encodings for the multi-core OR1K debug status/control register:
// write-target selector, mode bit positions and the per-core reset FSM states.
package adbg_or1k_mc_pkg;

    typedef enum logic [1:0] {
        MCSR_STALL = 2'd0,
        MCSR_RESET = 2'd1,
        MCSR_BPCLR = 2'd2,
        MCSR_MODE  = 2'd3
    } mcsr_sel_e;

    localparam int MODE_W               = 2;
    localparam int MODE_GROUP_HALT      = 0;
    localparam int MODE_STALL_AFTER_RST = 1;

    typedef enum logic {
        RST_IDLE   = 1'b0,
        RST_ACTIVE = 1'b1
    } rst_state_e;

endpackage

// File: rtl/adbg_or1k_mc_status_reg_if.sv
// Register write port driven by the debug-module decode into the status block.
interface adbg_or1k_mc_status_reg_if #(
    parameter int NB_CORES = 4
);

    logic                we;
    logic [1:0]          wsel;
    logic [NB_CORES-1:0] data;

    modport master (
        output we,
        output wsel,
        output data
    );

    modport slave (
        input we,
        input wsel,
        input data
    );

endinterface

// File: rtl/adbg_or1k_rst_pulse.sv
// One core's timed reset pulse: a reloadable down-counter with an IDLE/ACTIVE
// FSM; rst_o is the registered busy flag, so busy_o leads it by one clock.
module adbg_or1k_rst_pulse
    import adbg_or1k_mc_pkg::*;
#(
    parameter int RST_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic start_i,
    output logic rst_o,
    output logic busy_o,
    output logic done_o
);

    localparam int             CNT_W    = $clog2(RST_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    rst_state_e       state_q;
    rst_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             rst_q;
    logic             rst_d;

    // State, counter and reset output registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= RST_IDLE;
            cnt_q   <= '0;
            rst_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
        end
    end

    // Next-state logic: a start always reloads, so pulses only ever extend.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RST_IDLE: begin
                if (start_i) begin
                    state_d = RST_ACTIVE;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = RST_IDLE;
                    cnt_d   = '0;
                end
            end
            RST_ACTIVE: begin
                if (start_i) begin
                    state_d = RST_ACTIVE;
                    cnt_d   = CNT_LOAD;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = RST_IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = RST_ACTIVE;
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = RST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // A restart in the last high cycle holds rst_o so the pulse has no gap.
        rst_d = (cnt_q != '0) | (start_i & rst_q);
    end

    assign busy_o = (cnt_q != '0);
    assign rst_o  = rst_q;
    assign done_o = rst_q & ~busy_o & ~start_i;

endmodule

// File: rtl/adbg_or1k_mc_status_reg.sv
// Multi-core OR1K debug status/control register: per-core stall, sticky
// breakpoint flags, group-halt, timed reset pulses and stall-after-reset.
module adbg_or1k_mc_status_reg
    import adbg_or1k_mc_pkg::*;
#(
    parameter int NB_CORES   = 4,
    parameter int RST_CYCLES = 16
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    adbg_or1k_mc_status_reg_if.slave  wr_if,
    input  logic [NB_CORES-1:0]       bp_i,
    output logic [NB_CORES-1:0]       cpu_stall_o,
    output logic [NB_CORES-1:0]       cpu_rst_o,
    output logic [NB_CORES-1:0]       stall_reg_o,
    output logic [NB_CORES-1:0]       bp_hit_o,
    output logic [NB_CORES-1:0]       rst_busy_o,
    output logic [MODE_W-1:0]         mode_o
);

    logic [NB_CORES-1:0] stall_q;
    logic [NB_CORES-1:0] stall_d;
    logic [NB_CORES-1:0] bp_hit_q;
    logic [NB_CORES-1:0] bp_hit_d;
    logic [MODE_W-1:0]   mode_q;
    logic [MODE_W-1:0]   mode_d;

    logic [NB_CORES-1:0] start_s;
    logic [NB_CORES-1:0] rst_s;
    logic [NB_CORES-1:0] busy_s;
    logic [NB_CORES-1:0] done_s;
    logic [NB_CORES-1:0] bp_eff_s;
    logic [NB_CORES-1:0] bp_set_s;
    logic [NB_CORES-1:0] after_rst_s;
    logic [MODE_W-1:0]   mode_wdata_s;

    // A single-core build has only one data bit to carry the mode.
    if (NB_CORES >= 2) begin : g_mode_wide
        assign mode_wdata_s = wr_if.data[MODE_W-1:0];
    end else begin : g_mode_narrow
        assign mode_wdata_s = {1'b0, wr_if.data[0]};
    end

    for (genvar k = 0; k < NB_CORES; k++) begin : g_core
        adbg_or1k_rst_pulse #(
            .RST_CYCLES (RST_CYCLES)
        ) u_rst_pulse (
            .clk_i   (clk_i),
            .rstn_i  (rstn_i),
            .start_i (start_s[k]),
            .rst_o   (rst_s[k]),
            .busy_o  (busy_s[k]),
            .done_o  (done_s[k])
        );
    end

    // A core held in reset cannot raise a breakpoint; group-halt fans any hit out.
    assign bp_eff_s    = bp_i & ~rst_s;
    assign bp_set_s    = bp_eff_s | {NB_CORES{mode_q[MODE_GROUP_HALT] & (|bp_eff_s)}};
    assign after_rst_s = done_s & {NB_CORES{mode_q[MODE_STALL_AFTER_RST]}};

    // Write decode, then hardware sets applied last so they win over writes.
    always_comb begin
        stall_d  = stall_q;
        bp_hit_d = bp_hit_q;
        mode_d   = mode_q;
        start_s  = '0;
        if (wr_if.we) begin
            case (mcsr_sel_e'(wr_if.wsel))
                MCSR_STALL: stall_d = wr_if.data;
                MCSR_RESET: begin
                    start_s  = wr_if.data;
                    bp_hit_d = bp_hit_q & ~wr_if.data;
                end
                MCSR_BPCLR: bp_hit_d = bp_hit_q & ~wr_if.data;
                MCSR_MODE:  mode_d   = mode_wdata_s;
                default:    start_s  = '0;
            endcase
        end else begin
            start_s = '0;
        end
        stall_d  = stall_d | bp_set_s | after_rst_s;
        bp_hit_d = bp_hit_d | bp_eff_s;
    end

    // Status registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stall_q  <= '0;
            bp_hit_q <= '0;
            mode_q   <= 2'b00;
        end else begin
            stall_q  <= stall_d;
            bp_hit_q <= bp_hit_d;
            mode_q   <= mode_d;
        end
    end

    assign cpu_stall_o = bp_set_s | stall_q;
    assign cpu_rst_o   = rst_s;
    assign stall_reg_o = stall_q;
    assign bp_hit_o    = bp_hit_q;
    assign rst_busy_o  = busy_s;
    assign mode_o      = mode_q;

endmodule
